// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg
//   Shared definitions for the instruction-memory loader: FSM state encoding,
//   frame constants and small helper functions.
//   No ports (package).
package instr_mem_loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } state_e;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int          BYTE_W      = 8;
  localparam int          WORD_W      = 32;
  localparam int          LEN_W       = 16;
  localparam logic [31:0] WORD_STRIDE = 32'd4;

  // Running frame checksum: XOR of all data bytes.
  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

  // States that sit inside a frame waiting for a byte; only these are timed.
  function automatic logic in_frame(input state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if
//   Bundles the byte-stream handshake and the instruction-memory write port.
//   master : byte source / observer (drives byte_valid, byte_data)
//   slave  : the loader (drives byte_ready, im_write_*, core_reset, load_done, load_error)
interface instr_mem_loader_if;
  import instr_mem_loader_pkg::*;

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;
  logic              im_write_en;
  logic [WORD_W-1:0] im_write_addr;
  logic [WORD_W-1:0] im_write_data;
  logic              core_reset;
  logic              load_done;
  logic              load_error;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, im_write_en, im_write_addr, im_write_data,
    input  core_reset, load_done, load_error
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, im_write_en, im_write_addr, im_write_data,
    output core_reset, load_done, load_error
  );

endinterface

// File: rtl/instr_mem_loader_timeout.sv
// instr_mem_loader_timeout
//   Idle-cycle counter. Counts enabled cycles since the last clear and flags
//   expiry on the TIMEOUT_CYC-th consecutive enabled cycle.
//   clk, rst    : clock, asynchronous active-high reset
//   clr_i       : restart count at zero (wins over en_i)
//   en_i        : count this cycle
//   expired_o   : this is the TIMEOUT_CYC-th idle cycle
module instr_mem_loader_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, advance (saturating at LAST) or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of idle cycles already elapsed, so LAST marks the final one.
  assign expired_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Receives a framed program image (A5, LEN_HI, LEN_LO, 4*N data bytes, XOR checksum),
//   assembles big-endian words and writes them to instruction memory at consecutive
//   word addresses from BASE_ADDR. Holds the core in reset until a load completes
//   with a matching checksum.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : instr_mem_loader_if.slave (byte stream in, memory write port and status out)
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 256,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_mem_loader_if.slave    bus
);

  state_e             state_q,      state_d;
  logic [7:0]         len_hi_q,     len_hi_d;
  logic [LEN_W-1:0]   words_left_q, words_left_d;
  logic [1:0]         byte_cnt_q,   byte_cnt_d;
  logic [WORD_W-1:0]  word_q,       word_d;
  logic [7:0]         chk_q,        chk_d;
  logic [WORD_W-1:0]  addr_q,       addr_d;
  logic               wr_en_q,      wr_en_d;
  logic               core_reset_q, core_reset_d;
  logic               done_q,       done_d;
  logic               err_q,        err_d;

  logic               accept_s;
  logic               sync_s;
  logic [LEN_W-1:0]   len_s;
  logic               timer_clr_s;
  logic               timer_en_s;
  logic               expired_s;

  // WRITE is the only cycle in which no byte can be taken.
  assign bus.byte_ready = (state_q != ST_WRITE);
  assign accept_s       = bus.byte_valid && bus.byte_ready;
  assign sync_s         = accept_s && (bus.byte_data == SYNC_BYTE);
  assign len_s          = {len_hi_q, bus.byte_data};

  // Timer runs only while waiting for a byte inside a frame.
  assign timer_en_s  = in_frame(state_q) && !accept_s;
  assign timer_clr_s = !in_frame(state_q) || accept_s;

  instr_mem_loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (timer_clr_s),
    .en_i      (timer_en_s),
    .expired_o (expired_s)
  );

  // Next-state and datapath updates for the frame parser.
  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    words_left_d = words_left_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    chk_d        = chk_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    core_reset_d = core_reset_q;
    done_d       = done_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        // Only SYNC starts a frame here; everything else is discarded.
        if (sync_s) begin
          state_d      = ST_LEN_HI;
          core_reset_d = 1'b1;
          done_d       = 1'b0;
          err_d        = 1'b0;
          addr_d       = BASE_ADDR;
          chk_d        = 8'h00;
          byte_cnt_d   = 2'd0;
        end else begin
          state_d = state_q;
        end
      end

      ST_LEN_HI: begin
        if (expired_s) begin
          state_d      = ST_ERROR;
          core_reset_d = 1'b1;
          err_d        = 1'b1;
        end else if (accept_s) begin
          len_hi_d = bus.byte_data;
          state_d  = ST_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end

      ST_LEN_LO: begin
        if (expired_s) begin
          state_d      = ST_ERROR;
          core_reset_d = 1'b1;
          err_d        = 1'b1;
        end else if (accept_s) begin
          words_left_d = len_s;
          if ({16'd0, len_s} > MAX_WORDS) begin
            state_d      = ST_ERROR;
            core_reset_d = 1'b1;
            err_d        = 1'b1;
          end else if (len_s == 16'd0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_DATA: begin
        if (expired_s) begin
          state_d      = ST_ERROR;
          core_reset_d = 1'b1;
          err_d        = 1'b1;
        end else if (accept_s) begin
          word_d     = {word_q[23:0], bus.byte_data};
          chk_d      = chk_update(chk_q, bus.byte_data);
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Strobe is registered so it lines up with the WRITE cycle.
          if (byte_cnt_q == 2'd3) begin
            state_d = ST_WRITE;
            wr_en_d = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_WRITE: begin
        addr_d       = addr_q + WORD_STRIDE;
        words_left_d = words_left_q - 16'd1;
        if (words_left_q == 16'd1) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_CHECK: begin
        if (expired_s) begin
          state_d      = ST_ERROR;
          core_reset_d = 1'b1;
          err_d        = 1'b1;
        end else if (accept_s) begin
          if (bus.byte_data == chk_q) begin
            state_d      = ST_DONE;
            core_reset_d = 1'b0;
            done_d       = 1'b1;
          end else begin
            state_d      = ST_ERROR;
            core_reset_d = 1'b1;
            err_d        = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        core_reset_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_hi_q     <= 8'h00;
      words_left_q <= 16'd0;
      byte_cnt_q   <= 2'd0;
      word_q       <= 32'h0000_0000;
      chk_q        <= 8'h00;
      addr_q       <= BASE_ADDR;
      wr_en_q      <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      words_left_q <= words_left_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      chk_q        <= chk_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.im_write_en   = wr_en_q;
  assign bus.im_write_addr = addr_q;
  assign bus.im_write_data = word_q;
  assign bus.core_reset    = core_reset_q;
  assign bus.load_done     = done_q;
  assign bus.load_error    = err_q;

endmodule
